// File: rtl/counter_bus_if_pkg.sv
// counter_bus_if_pkg: register map, load FSM encoding and tick ratios shared by the counter bus interface
package counter_bus_if_pkg;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_VALUE = 2'd1;
  localparam logic [1:0] ADDR_PRESC = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT_TICK = 2'd2;
  localparam int TICK_DIV1 = 4;
  localparam int TICK_DIV2 = 16;
  localparam int DIV1_W = $clog2(TICK_DIV1);
  localparam int DIV_W = $clog2(TICK_DIV2);
endpackage

// File: rtl/counter_tick_gen.sv
// counter_tick_gen: prescaled tick enables clk0 (every presc+1 cycles), clk1 (every 4th clk0), clk2 (every 16th clk0)
// clk, reset (sync, active-low), clr (sync restart of prescaler and dividers), presc in; clk0/clk1/clk2 out
module counter_tick_gen
  import counter_bus_if_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               clk0,
  output logic               clk1,
  output logic               clk2
);
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic tick;
  always_comb begin
    tick = cnt_q == presc;
    cnt_d = clr || tick ? '0 : cnt_q + 1'b1;
    div_d = clr ? '0 : tick ? div_q + 1'b1 : div_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end
  // one shared divider: its low bits give the 1:4 ratio, the full count the 1:16 ratio
  assign clk0 = reset && tick;
  assign clk1 = clk0 && div_q[DIV1_W-1:0] == DIV1_W'(TICK_DIV1 - 1);
  assign clk2 = clk0 && div_q == DIV_W'(TICK_DIV2 - 1);
endmodule

// File: rtl/counter_bus_if.sv
// counter_bus_if: CPU register interface (CTRL/VALUE/PRESC/STATUS) to a 3-channel counter stage with tick and irq generation
// bus_en/we/addr/wdata in, bus_rdata/bus_ready out (1-cycle registered); counter_we/ch/val load strobe out;
// counter_out and counter0..2_out in; clk0..2 tick enables out; irq out
module counter_bus_if
  import counter_bus_if_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_en,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        counter_we,
  output logic [1:0]  counter_ch,
  output logic [31:0] counter_val,
  input  logic [31:0] counter_out,
  input  logic        counter0_out,
  input  logic        counter1_out,
  input  logic        counter2_out,
  output logic        clk0,
  output logic        clk1,
  output logic        clk2,
  output logic        irq
);
  logic [4:0] ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [2:0] status_q, status_d, hist_q, flags, rise, w1c;
  logic [1:0] state_q, state_d, ch_q, ch_d;
  logic [31:0] val_q, val_d, rdata_q, rdata_d, rd_mux;
  logic ready_q, ready_d, irq_q, irq_d;
  logic acc, wr, load, done, presc_wr, tick_sel;
  assign flags = {counter2_out, counter1_out, counter0_out};
  counter_tick_gen #(.PRESC_W(PRESC_W)) u_tick (
    .clk(clk), .reset(reset), .clr(presc_wr), .presc(presc_q),
    .clk0(clk0), .clk1(clk1), .clk2(clk2)
  );
  always_comb begin
    acc = bus_en && state_q == ST_IDLE;
    wr = acc && bus_we;
    presc_wr = wr && bus_addr == ADDR_PRESC;
    load = wr && bus_addr == ADDR_VALUE && ctrl_q[1:0] != 2'd3;
    tick_sel = ch_q == 2'd0 ? clk0 : ch_q == 2'd1 ? clk1 : clk2;
    done = state_q == ST_WAIT_TICK && tick_sel;
    rise = flags & ~hist_q;
    w1c = wr && bus_addr == ADDR_STATUS ? bus_wdata[2:0] : 3'b0;
    ctrl_d = wr && bus_addr == ADDR_CTRL ? bus_wdata[4:0] : ctrl_q;
    presc_d = presc_wr ? bus_wdata[PRESC_W-1:0] : presc_q;
    status_d = (status_q & ~w1c) | rise;
    irq_d = |(status_q & ctrl_q[4:2]);
    state_d = load ? ST_STROBE : state_q == ST_STROBE ? ST_WAIT_TICK : done ? ST_IDLE : state_q;
    val_d = load ? bus_wdata : val_q;
    ch_d = load ? ctrl_q[1:0] : ch_q;
    ready_d = (acc && !load) || done;
    rd_mux = bus_addr == ADDR_CTRL ? {27'b0, ctrl_q} :
             bus_addr == ADDR_VALUE ? counter_out :
             bus_addr == ADDR_PRESC ? 32'(presc_q) : {29'b0, status_q};
    rdata_d = acc && !bus_we ? rd_mux : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q <= '0;
      presc_q <= '0;
      status_q <= '0;
      hist_q <= flags;
      state_q <= ST_IDLE;
      ch_q <= '0;
      val_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      presc_q <= presc_d;
      status_q <= status_d;
      hist_q <= flags;
      state_q <= state_d;
      ch_q <= ch_d;
      val_q <= val_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      irq_q <= irq_d;
    end
  end
  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;
  assign counter_we = state_q == ST_STROBE;
  assign counter_ch = ch_q;
  assign counter_val = val_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_counter_bus_if.sv
// tb_counter_bus_if: scoreboard bench for counter_bus_if with directed register, tick, load and irq vectors
module tb_counter_bus_if;
  logic clk = 0, reset = 0, bus_en = 0, bus_we = 0;
  logic [1:0] bus_addr = 0;
  logic [31:0] bus_wdata = 0, counter_out = 32'hDEAD_BEEF;
  logic counter0_out = 0, counter1_out = 0, counter2_out = 0;
  logic [31:0] bus_rdata, counter_val;
  logic bus_ready, counter_we, clk0, clk1, clk2, irq;
  logic [1:0] counter_ch;
  typedef struct {
    logic rd;
    logic [31:0] data;
    string name;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, we_cnt = 0;

  counter_bus_if #(.PRESC_W(16)) dut (
    .clk(clk), .reset(reset), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .counter_we(counter_we), .counter_ch(counter_ch), .counter_val(counter_val),
    .counter_out(counter_out), .counter0_out(counter0_out), .counter1_out(counter1_out),
    .counter2_out(counter2_out), .clk0(clk0), .clk1(clk1), .clk2(clk2), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      step();
      if (counter_we) we_cnt++;
      if (bus_ready) begin
        if (sb.size() == 0) check("spurious_ready", {31'b0, bus_ready}, 32'd0);
        else begin
          e = sb.pop_front();
          if (e.rd) check(e.name, bus_rdata, e.data);
        end
      end
    end
  end

  task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d, input int skip,
                     output int cyc);
    int s;
    bit done;
    s = skip;
    done = 0;
    cyc = 0;
    bus_en = 1;
    bus_we = we;
    bus_addr = a;
    bus_wdata = d;
    while (!done && cyc < 1000) begin
      step();
      cyc++;
      if (bus_ready) begin
        if (s == 0) done = 1;
        else s--;
      end
    end
    bus_en = 0;
    if (!done) check("bus_timeout", {31'b0, bus_ready}, 32'd1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int cyc);
    sb.push_back('{1'b0, 32'h0, "wr"});
    bus(1'b1, a, d, 0, cyc);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] x, input string n, input int skip);
    int c;
    sb.push_back('{1'b1, x, n});
    bus(1'b0, a, 32'h0, skip, c);
  endtask

  task automatic check_reset_outputs();
    check("rst_counter_we", {31'b0, counter_we}, 0);
    check("rst_counter_val", counter_val, 0);
    check("rst_counter_ch", {30'b0, counter_ch}, 0);
    check("rst_ticks", {29'b0, clk2, clk1, clk0}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    check("rst_ready", {31'b0, bus_ready}, 0);
    check("rst_rdata", bus_rdata, 0);
  endtask

  initial begin
    int c, w0;
    repeat (3) step();
    check_reset_outputs();
    reset = 1;
    rd(2'd0, 32'h0, "ctrl_reset", 0);
    rd(2'd2, 32'h0, "presc_reset", 0);
    rd(2'd3, 32'h0, "status_reset", 0);
    rd(2'd1, 32'hDEAD_BEEF, "value_read", 0);
    for (int k = 0; k < 5; k++) begin
      check("presc0_clk0", {31'b0, clk0}, 1);
      step();
    end
    wr(2'd2, 32'd3, c);
    check("presc_wr_1cyc", c, 1);
    for (int k = 1; k <= 130; k++) begin
      check("ticks_presc3", {29'b0, clk2, clk1, clk0},
            {29'b0, k % 64 == 0, k % 16 == 0, k % 4 == 0});
      step();
    end
    rd(2'd2, 32'd3, "presc_read", 0);
    wr(2'd2, 32'd9, c);
    sb.push_back('{1'b0, 32'h0, "value_wr"});
    bus_en = 1;
    bus_we = 1;
    bus_addr = 2'd1;
    bus_wdata = 32'h100;
    for (int j = 1; j <= 12; j++) begin
      step();
      check("load_we", {31'b0, counter_we}, {31'b0, j == 1});
      if (j == 1) begin
        check("load_val", counter_val, 32'h100);
        check("load_ch", {30'b0, counter_ch}, 0);
      end
      check("load_ready", {31'b0, bus_ready}, {31'b0, j == 10});
      if (j == 10) bus_en = 0;
    end
    wr(2'd0, 32'h5, c);
    sb.push_back('{1'b0, 32'h0, "value_wr_ch1"});
    bus_en = 1;
    bus_we = 1;
    bus_addr = 2'd1;
    bus_wdata = 32'hABCD;
    step();
    bus_en = 0;
    check("strobe_we", {31'b0, counter_we}, 1);
    check("strobe_ch", {30'b0, counter_ch}, 1);
    sb.push_back('{1'b1, 32'h5, "ctrl_after_stall"});
    bus(1'b0, 2'd0, 32'h0, 1, c);
    check("read_stalled", {31'b0, c >= 3}, 1);
    wr(2'd0, 32'h3, c);
    rd(2'd0, 32'h3, "ctrl_ch3", 0);
    w0 = we_cnt;
    wr(2'd1, 32'h55, c);
    check("ch3_value_1cyc", c, 1);
    repeat (3) step();
    check("ch3_no_we", we_cnt, w0);
    wr(2'd0, 32'h08, c);
    counter1_out = 1;
    step();
    check("irq_delay", {31'b0, irq}, 0);
    step();
    check("irq_set", {31'b0, irq}, 1);
    rd(2'd3, 32'h2, "status_set1", 0);
    wr(2'd3, 32'h2, c);
    check("irq_hold", {31'b0, irq}, 1);
    step();
    check("irq_clear", {31'b0, irq}, 0);
    counter0_out = 1;
    step();
    counter0_out = 0;
    step();
    counter0_out = 1;
    wr(2'd3, 32'h1, c);
    rd(2'd3, 32'h1, "status_set_wins", 0);
    wr(2'd3, 32'h1, c);
    rd(2'd3, 32'h0, "status_w1c", 0);
    check("irq_masked", {31'b0, irq}, 0);
    wr(2'd0, 32'h0, c);
    bus_en = 1;
    bus_we = 1;
    bus_addr = 2'd1;
    bus_wdata = 32'h77;
    step();
    bus_en = 0;
    repeat (3) step();
    w0 = we_cnt;
    reset = 0;
    counter2_out = 1;
    step();
    check_reset_outputs();
    step();
    check_reset_outputs();
    reset = 1;
    repeat (30) step();
    check("abort_no_we", we_cnt, w0);
    check("abort_clk0", {31'b0, clk0}, 1);
    rd(2'd3, 32'h0, "status_no_set_after_reset", 0);
    rd(2'd2, 32'h0, "presc_after_reset", 0);
    rd(2'd0, 32'h0, "ctrl_after_reset", 0);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
